// File: rtl/microseq_ctrl.sv
// microseq_ctrl: microcoded control sequencer for a multi-cycle RV32I/RV64I datapath.
// It owns the instruction register, the step counter and the immediate decode.
// All strobes are decoded combinationally from the registered {ir, step}.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   bus_in[XLEN]                     shared bus, captured into ir at fetch
//   mem_ready                        memory ack, stalls fetch/load/store steps
//   alu_eq, alu_lt, alu_ltu          ALU compare flags for branches
//   imm_out[XLEN], imm_oe            sign-extended immediate and its bus enable
//   reg_idx[5], reg_en, reg_write    register file select / drive / write
//   pc_addr, pc_bus, pc_inc, pc_write
//   mem_read, mem_write, mem_size[3]
//   a_write, b_write, alu_bus, alu_addr, alu_op[4]
//   step[STEP_BITS], instr_done, trap
//
// step | meaning
// 0    | fetch: pc_addr + mem_read, ir <= bus_in on mem_ready
// 1    | operand A (rs1 or pc); LUI writes rd; illegal decode traps here
// 2    | operand B (rs2 or immediate)
// 3    | result / memory access / branch decision / JAL(R) pc_inc
// 4    | JAL(R) link write; taken branch loads the offset into B
// 5    | JAL(R) and taken branch write the target into pc
module microseq_ctrl #(
  parameter int XLEN            = 32,
  parameter int STEP_BITS       = 3,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      bus_in,
  input  logic                 mem_ready,
  input  logic                 alu_eq,
  input  logic                 alu_lt,
  input  logic                 alu_ltu,
  output logic [XLEN-1:0]      imm_out,
  output logic                 imm_oe,
  output logic [4:0]           reg_idx,
  output logic                 pc_addr,
  output logic                 pc_bus,
  output logic                 pc_inc,
  output logic                 pc_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [2:0]           mem_size,
  output logic                 reg_en,
  output logic                 reg_write,
  output logic                 a_write,
  output logic                 b_write,
  output logic                 alu_bus,
  output logic                 alu_addr,
  output logic [3:0]           alu_op,
  output logic [STEP_BITS-1:0] step,
  output logic                 instr_done,
  output logic                 trap
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [STEP_BITS-1:0] S0 = STEP_BITS'(0);
  localparam logic [STEP_BITS-1:0] S1 = STEP_BITS'(1);
  localparam logic [STEP_BITS-1:0] S2 = STEP_BITS'(2);
  localparam logic [STEP_BITS-1:0] S3 = STEP_BITS'(3);
  localparam logic [STEP_BITS-1:0] S4 = STEP_BITS'(4);
  localparam logic [STEP_BITS-1:0] S5 = STEP_BITS'(5);

  logic [31:0]          ir;
  logic [STEP_BITS-1:0] step_q;
  logic                 trap_q;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

  logic [31:0] imm32;
  always_comb begin
    case (opcode)
      OPC_STORE:            imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH:           imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:   imm32 = {ir[31:12], 12'b0};
      OPC_JAL:              imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:              imm32 = {{20{ir[31]}}, ir[31:20]};
    endcase
  end
  assign imm_out = XLEN'($signed(imm32));

  // funct3[0] inverts the sense of the base compare selected by funct3[2:1]
  logic br_base, br_taken;
  always_comb begin
    case (funct3[2:1])
      2'b00:   br_base = alu_eq;
      2'b10:   br_base = alu_lt;
      2'b11:   br_base = alu_ltu;
      default: br_base = 1'b0;
    endcase
    br_taken = br_base ^ funct3[0];
  end

  // every listed opcode ends in 2'b11, so a non-32-bit encoding is illegal too
  logic legal;
  always_comb begin
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: legal = 1'b1;
      OPC_BRANCH:                             legal = (funct3[2:1] != 2'b01);
      default:                                legal = 1'b0;
    endcase
  end

  logic imm_oe_c, pc_addr_c, pc_bus_c, pc_inc_c, pc_write_c, mem_read_c, mem_write_c;
  logic reg_en_c, reg_write_c, a_write_c, b_write_c, alu_bus_c, alu_addr_c;
  logic [4:0] reg_idx_c;
  logic [3:0] alu_op_c;
  logic [2:0] mem_size_c;
  logic       last_c, mem_step_c, hold_c, set_trap_c, advance;

  always_comb begin
    imm_oe_c = 1'b0;    pc_addr_c = 1'b0;   pc_bus_c = 1'b0;    pc_inc_c = 1'b0;
    pc_write_c = 1'b0;  mem_read_c = 1'b0;  mem_write_c = 1'b0; reg_en_c = 1'b0;
    reg_write_c = 1'b0; a_write_c = 1'b0;   b_write_c = 1'b0;   alu_bus_c = 1'b0;
    alu_addr_c = 1'b0;  reg_idx_c = '0;     alu_op_c = '0;      mem_size_c = '0;
    last_c = 1'b0;      mem_step_c = 1'b0;  hold_c = 1'b0;      set_trap_c = 1'b0;
    if (step_q == S0) begin
      pc_addr_c = 1'b1; mem_read_c = 1'b1; mem_step_c = 1'b1;
    end else if (trap_q) begin
      hold_c = 1'b1;
    end else if (!legal) begin
      if (TRAP_ON_ILLEGAL != 0) begin
        hold_c = 1'b1; set_trap_c = 1'b1;
      end else begin
        pc_inc_c = 1'b1; last_c = 1'b1;
      end
    end else begin
      case (opcode)
        OPC_LUI: begin
          imm_oe_c = 1'b1; reg_idx_c = rd; reg_write_c = 1'b1; pc_inc_c = 1'b1; last_c = 1'b1;
        end
        OPC_AUIPC: begin
          case (step_q)
            S1:      begin pc_bus_c = 1'b1; a_write_c = 1'b1; end
            S2:      begin imm_oe_c = 1'b1; b_write_c = 1'b1; end
            default: begin
              alu_bus_c = 1'b1; reg_idx_c = rd; reg_write_c = 1'b1; pc_inc_c = 1'b1; last_c = 1'b1;
            end
          endcase
        end
        OPC_JAL, OPC_JALR: begin
          case (step_q)
            S1: begin
              a_write_c = 1'b1;
              if (opcode == OPC_JALR) begin reg_idx_c = rs1; reg_en_c = 1'b1; end
              else pc_bus_c = 1'b1;
            end
            S2:      begin imm_oe_c = 1'b1; b_write_c = 1'b1; end
            S3:      pc_inc_c = 1'b1;
            S4:      begin pc_bus_c = 1'b1; reg_idx_c = rd; reg_write_c = 1'b1; end
            default: begin alu_bus_c = 1'b1; pc_write_c = 1'b1; last_c = 1'b1; end
          endcase
        end
        OPC_BRANCH: begin
          // steps 4-5 are only reachable when step 3 saw the branch taken
          case (step_q)
            S1: begin reg_idx_c = rs1; reg_en_c = 1'b1; a_write_c = 1'b1; end
            S2: begin reg_idx_c = rs2; reg_en_c = 1'b1; b_write_c = 1'b1; end
            S3: begin
              if (br_taken) begin pc_bus_c = 1'b1; a_write_c = 1'b1; end
              else begin pc_inc_c = 1'b1; last_c = 1'b1; end
            end
            S4:      begin imm_oe_c = 1'b1; b_write_c = 1'b1; end
            default: begin alu_bus_c = 1'b1; pc_write_c = 1'b1; last_c = 1'b1; end
          endcase
        end
        default: begin
          // LOAD, STORE, OP-IMM, OP share rs1 -> A then B then one result step
          case (step_q)
            S1: begin reg_idx_c = rs1; reg_en_c = 1'b1; a_write_c = 1'b1; end
            S2: begin
              b_write_c = 1'b1;
              if (opcode == OPC_OP) begin reg_idx_c = rs2; reg_en_c = 1'b1; end
              else imm_oe_c = 1'b1;
            end
            default: begin
              pc_inc_c = 1'b1; last_c = 1'b1;
              case (opcode)
                OPC_LOAD: begin
                  alu_addr_c = 1'b1; mem_read_c = 1'b1; reg_idx_c = rd; reg_write_c = 1'b1;
                  mem_step_c = 1'b1; mem_size_c = funct3;
                end
                OPC_STORE: begin
                  alu_addr_c = 1'b1; reg_idx_c = rs2; reg_en_c = 1'b1; mem_write_c = 1'b1;
                  mem_step_c = 1'b1; mem_size_c = funct3;
                end
                default: begin
                  // for OP-IMM only the shift-right funct3 carries funct7[5] (SRAI vs SRLI)
                  alu_bus_c = 1'b1; reg_idx_c = rd; reg_write_c = 1'b1;
                  alu_op_c = {ir[30] & ((opcode == OPC_OP) | (funct3 == 3'b101)), funct3};
                end
              endcase
            end
          endcase
        end
      endcase
    end
  end

  assign advance = !hold_c && !(mem_step_c && !mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      ir     <= 32'h0000_0013;
      step_q <= S0;
      trap_q <= 1'b0;
    end else begin
      if (set_trap_c) trap_q <= 1'b1;
      if (advance) begin
        if (step_q == S0) begin
          ir     <= bus_in[31:0];
          step_q <= S1;
        end else if (last_c) begin
          step_q <= S0;
        end else begin
          step_q <= step_q + S1;
        end
      end
    end
  end

  assign imm_oe     = imm_oe_c    & ~reset;
  assign pc_addr    = pc_addr_c   & ~reset;
  assign pc_bus     = pc_bus_c    & ~reset;
  assign pc_inc     = pc_inc_c    & ~reset;
  assign pc_write   = pc_write_c  & ~reset;
  assign mem_read   = mem_read_c  & ~reset;
  assign mem_write  = mem_write_c & ~reset;
  assign reg_en     = reg_en_c    & ~reset;
  assign reg_write  = reg_write_c & (rd != 5'd0) & ~reset;
  assign a_write    = a_write_c   & ~reset;
  assign b_write    = b_write_c   & ~reset;
  assign alu_bus    = alu_bus_c   & ~reset;
  assign alu_addr   = alu_addr_c  & ~reset;
  assign reg_idx    = reset ? 5'd0 : reg_idx_c;
  assign alu_op     = reset ? 4'd0 : alu_op_c;
  assign mem_size   = reset ? 3'd0 : mem_size_c;
  assign step       = reset ? S0 : step_q;
  assign instr_done = last_c & advance & ~reset;
  assign trap       = trap_q & ~reset;

endmodule

// File: tb/tb_microseq_ctrl.sv
// Testbench for microseq_ctrl: u1 traps on illegal instructions, u0 treats them as NOPs.
// Expected control words for u1 are queued ahead of each instruction and a negedge
// monitor pops one per non-fetch cycle.
module tb_microseq_ctrl;

  localparam logic [14:0] IMM_OE = 15'h4000, PC_ADDR = 15'h2000, PC_BUS = 15'h1000;
  localparam logic [14:0] PC_INC = 15'h0800, PC_WRITE = 15'h0400, MEM_READ = 15'h0200;
  localparam logic [14:0] MEM_WRITE = 15'h0100, REG_EN = 15'h0080, REG_WRITE = 15'h0040;
  localparam logic [14:0] A_WRITE = 15'h0020, B_WRITE = 15'h0010, ALU_BUS = 15'h0008;
  localparam logic [14:0] ALU_ADDR = 15'h0004, DONE = 15'h0002, TRAP = 15'h0001;
  localparam logic [14:0] RA = REG_EN | A_WRITE, RB = REG_EN | B_WRITE;
  localparam logic [14:0] IB = IMM_OE | B_WRITE, PA = PC_BUS | A_WRITE;

  typedef struct packed {
    logic [7:0]  tag;
    logic [2:0]  st;
    logic [14:0] s;
    logic [4:0]  idx;
    logic [3:0]  op;
    logic [2:0]  msz;
    logic        ci;
    logic [31:0] imm;
  } exp_t;

  logic clk, reset, mem_ready, alu_eq, alu_lt, alu_ltu;
  logic [31:0] bus_in;

  logic [31:0] imm_1, imm_0;
  logic [4:0]  idx_1, idx_0;
  logic [2:0]  msz_1, msz_0, step_1, step_0;
  logic [3:0]  op_1, op_0;
  logic imm_oe_1, pc_addr_1, pc_bus_1, pc_inc_1, pc_write_1, mem_read_1, mem_write_1;
  logic reg_en_1, reg_write_1, a_write_1, b_write_1, alu_bus_1, alu_addr_1, done_1, trap_1;
  logic imm_oe_0, pc_addr_0, pc_bus_0, pc_inc_0, pc_write_0, mem_read_0, mem_write_0;
  logic reg_en_0, reg_write_0, a_write_0, b_write_0, alu_bus_0, alu_addr_0, done_0, trap_0;
  logic [14:0] act_1, act_0;

  assign act_1 = {imm_oe_1, pc_addr_1, pc_bus_1, pc_inc_1, pc_write_1, mem_read_1, mem_write_1,
                  reg_en_1, reg_write_1, a_write_1, b_write_1, alu_bus_1, alu_addr_1, done_1, trap_1};
  assign act_0 = {imm_oe_0, pc_addr_0, pc_bus_0, pc_inc_0, pc_write_0, mem_read_0, mem_write_0,
                  reg_en_0, reg_write_0, a_write_0, b_write_0, alu_bus_0, alu_addr_0, done_0, trap_0};

  microseq_ctrl #(.XLEN(32), .STEP_BITS(3), .TRAP_ON_ILLEGAL(1)) u1 (
    .clk(clk), .reset(reset), .bus_in(bus_in), .mem_ready(mem_ready),
    .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .imm_out(imm_1), .imm_oe(imm_oe_1), .reg_idx(idx_1),
    .pc_addr(pc_addr_1), .pc_bus(pc_bus_1), .pc_inc(pc_inc_1), .pc_write(pc_write_1),
    .mem_read(mem_read_1), .mem_write(mem_write_1), .mem_size(msz_1),
    .reg_en(reg_en_1), .reg_write(reg_write_1), .a_write(a_write_1), .b_write(b_write_1),
    .alu_bus(alu_bus_1), .alu_addr(alu_addr_1), .alu_op(op_1), .step(step_1),
    .instr_done(done_1), .trap(trap_1));

  microseq_ctrl #(.XLEN(32), .STEP_BITS(3), .TRAP_ON_ILLEGAL(0)) u0 (
    .clk(clk), .reset(reset), .bus_in(bus_in), .mem_ready(mem_ready),
    .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .imm_out(imm_0), .imm_oe(imm_oe_0), .reg_idx(idx_0),
    .pc_addr(pc_addr_0), .pc_bus(pc_bus_0), .pc_inc(pc_inc_0), .pc_write(pc_write_0),
    .mem_read(mem_read_0), .mem_write(mem_write_0), .mem_size(msz_0),
    .reg_en(reg_en_0), .reg_write(reg_write_0), .a_write(a_write_0), .b_write(b_write_0),
    .alu_bus(alu_bus_0), .alu_addr(alu_addr_0), .alu_op(op_0), .step(step_0),
    .instr_done(done_0), .trap(trap_0));

  exp_t q[$];
  exp_t e;
  int n_checks = 0;
  int n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!reset && step_1 != 3'd0) begin
      n_checks++;
      if (q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_output: got step=%0d strobes=%h, want no control word", step_1, act_1);
      end else begin
        e = q.pop_front();
        if (step_1 !== e.st || act_1 !== e.s || idx_1 !== e.idx || op_1 !== e.op ||
            msz_1 !== e.msz || (e.ci && imm_1 !== e.imm)) begin
          n_errors++;
          $display("FAIL t%0d_step%0d: got st=%0d s=%h idx=%0d op=%h msz=%0d imm=%h want st=%0d s=%h idx=%0d op=%h msz=%0d imm=%h",
                   e.tag, e.st, step_1, act_1, idx_1, op_1, msz_1, imm_1,
                   e.st, e.s, e.idx, e.op, e.msz, e.imm);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic ex(input logic [7:0] tag, input logic [2:0] st, input logic [14:0] s,
                    input logic [4:0] idx, input logic [3:0] op, input logic [2:0] msz,
                    input logic ci, input logic [31:0] imm);
    exp_t x;
    x = '{tag: tag, st: st, s: s, idx: idx, op: op, msz: msz, ci: ci, imm: imm};
    q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) cyc();
  endtask

  task automatic rst_cycles(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_strobes", 32'(act_1), 32'(0));
      chk("rst_fields", {15'(0), step_1, idx_1, op_1, msz_1, act_0[0]}, 32'(0));
      cyc();
    end
    reset = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] instr, input int stalls);
    for (int i = 0; i < stalls; i++) begin
      bus_in = 32'hDEAD_BEEF;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("fetch_stall_strobes", 32'(act_1), 32'(PC_ADDR | MEM_READ));
      cyc();
    end
    bus_in = instr;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("fetch_strobes", 32'(act_1), 32'(PC_ADDR | MEM_READ));
    chk("fetch_step_size", {26'(0), step_1, msz_1}, 32'(0));
    cyc();
  endtask

  task automatic illegal_test(input logic [7:0] tag, input logic [31:0] instr);
    ex(tag, 3'd1, 15'h0, 5'd0, 4'd0, 3'd0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) ex(tag, 3'd1, TRAP, 5'd0, 4'd0, 3'd0, 1'b0, 32'h0);
    do_fetch(instr, 0);
    bus_in = 32'h0000_0013;
    @(negedge clk);
    chk("nop_mode_step1", 32'(act_0), 32'(PC_INC | DONE));
    chk("nop_mode_stepno", 32'(step_0), 32'd1);
    cyc();
    steps(4);
    rst_cycles(1);
  endtask

  initial begin
    reset = 1'b1; bus_in = 32'h0; mem_ready = 1'b1;
    alu_eq = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
    rst_cycles(3);

    // addi x5,x0,7
    ex(1, 1, RA, 0, 0, 0, 0, 0);
    ex(1, 2, IB, 0, 0, 0, 1, 32'd7);
    ex(1, 3, ALU_BUS | REG_WRITE | PC_INC | DONE, 5, 0, 0, 0, 0);
    do_fetch(32'h0070_0293, 0); steps(3);

    // beq x1,x2,8 taken (fetch stalled one cycle first)
    ex(2, 1, RA, 1, 0, 0, 0, 0);
    ex(2, 2, RB, 2, 0, 0, 0, 0);
    ex(2, 3, PA, 0, 0, 0, 0, 0);
    ex(2, 4, IB, 0, 0, 0, 1, 32'd8);
    ex(2, 5, ALU_BUS | PC_WRITE | DONE, 0, 0, 0, 0, 0);
    do_fetch(32'h0020_8463, 1); alu_eq = 1'b1; steps(5); alu_eq = 1'b0;

    // beq not taken
    ex(3, 1, RA, 1, 0, 0, 0, 0);
    ex(3, 2, RB, 2, 0, 0, 0, 0);
    ex(3, 3, PC_INC | DONE, 0, 0, 0, 0, 0);
    do_fetch(32'h0020_8463, 0); steps(3);

    // bne with eq=1 -> not taken
    ex(4, 1, RA, 1, 0, 0, 0, 0);
    ex(4, 2, RB, 2, 0, 0, 0, 0);
    ex(4, 3, PC_INC | DONE, 0, 0, 0, 0, 0);
    do_fetch(32'h0020_9463, 0); alu_eq = 1'b1; steps(3); alu_eq = 1'b0;

    // bltu with ltu=1, lt=0 -> taken
    ex(5, 1, RA, 1, 0, 0, 0, 0);
    ex(5, 2, RB, 2, 0, 0, 0, 0);
    ex(5, 3, PA, 0, 0, 0, 0, 0);
    ex(5, 4, IB, 0, 0, 0, 1, 32'd8);
    ex(5, 5, ALU_BUS | PC_WRITE | DONE, 0, 0, 0, 0, 0);
    do_fetch(32'h0020_E463, 0); alu_ltu = 1'b1; steps(5); alu_ltu = 1'b0;

    // bge with lt=1 -> not taken
    ex(6, 1, RA, 1, 0, 0, 0, 0);
    ex(6, 2, RB, 2, 0, 0, 0, 0);
    ex(6, 3, PC_INC | DONE, 0, 0, 0, 0, 0);
    do_fetch(32'h0020_D463, 0); alu_lt = 1'b1; steps(3); alu_lt = 1'b0;

    // lw x3,4(x1) with two wait states in the access step
    ex(7, 1, RA, 1, 0, 0, 0, 0);
    ex(7, 2, IB, 0, 0, 0, 1, 32'd4);
    ex(7, 3, ALU_ADDR | MEM_READ | REG_WRITE | PC_INC, 3, 0, 3'b010, 1, 32'd4);
    ex(7, 3, ALU_ADDR | MEM_READ | REG_WRITE | PC_INC, 3, 0, 3'b010, 1, 32'd4);
    ex(7, 3, ALU_ADDR | MEM_READ | REG_WRITE | PC_INC | DONE, 3, 0, 3'b010, 1, 32'd4);
    do_fetch(32'h0040_A183, 0); steps(2);
    mem_ready = 1'b0; steps(2); mem_ready = 1'b1; steps(1);

    // sw x2,8(x1)
    ex(8, 1, RA, 1, 0, 0, 0, 0);
    ex(8, 2, IB, 0, 0, 0, 1, 32'd8);
    ex(8, 3, ALU_ADDR | REG_EN | MEM_WRITE | PC_INC | DONE, 2, 0, 3'b010, 0, 0);
    do_fetch(32'h0020_A423, 0); steps(3);

    // addi x0,x0,0: no register write
    ex(9, 1, RA, 0, 0, 0, 0, 0);
    ex(9, 2, IB, 0, 0, 0, 1, 32'd0);
    ex(9, 3, ALU_BUS | PC_INC | DONE, 0, 0, 0, 0, 0);
    do_fetch(32'h0000_0013, 0); steps(3);

    // sub x6,x1,x2
    ex(10, 1, RA, 1, 0, 0, 0, 0);
    ex(10, 2, RB, 2, 0, 0, 0, 0);
    ex(10, 3, ALU_BUS | REG_WRITE | PC_INC | DONE, 6, 4'h8, 0, 0, 0);
    do_fetch(32'h4020_8333, 0); steps(3);

    // srai x7,x1,3
    ex(11, 1, RA, 1, 0, 0, 0, 0);
    ex(11, 2, IB, 0, 0, 0, 1, 32'h0000_0403);
    ex(11, 3, ALU_BUS | REG_WRITE | PC_INC | DONE, 7, 4'hD, 0, 0, 0);
    do_fetch(32'h4030_D393, 0); steps(3);

    // addi x5,x0,-1024: negative immediate, bit30 must not reach alu_op
    ex(12, 1, RA, 0, 0, 0, 0, 0);
    ex(12, 2, IB, 0, 0, 0, 1, 32'hFFFF_FC00);
    ex(12, 3, ALU_BUS | REG_WRITE | PC_INC | DONE, 5, 4'h0, 0, 0, 0);
    do_fetch(32'hC000_0293, 0); steps(3);

    // lui x5,0x12345
    ex(13, 1, IMM_OE | REG_WRITE | PC_INC | DONE, 5, 0, 0, 1, 32'h1234_5000);
    do_fetch(32'h1234_52B7, 0); steps(1);

    // auipc x4,0xFFFFF
    ex(14, 1, PA, 0, 0, 0, 0, 0);
    ex(14, 2, IB, 0, 0, 0, 1, 32'hFFFF_F000);
    ex(14, 3, ALU_BUS | REG_WRITE | PC_INC | DONE, 4, 0, 0, 0, 0);
    do_fetch(32'hFFFF_F217, 0); steps(3);

    // jal x1,16
    ex(15, 1, PA, 0, 0, 0, 0, 0);
    ex(15, 2, IB, 0, 0, 0, 1, 32'd16);
    ex(15, 3, PC_INC, 0, 0, 0, 0, 0);
    ex(15, 4, PC_BUS | REG_WRITE, 1, 0, 0, 0, 0);
    ex(15, 5, ALU_BUS | PC_WRITE | DONE, 0, 0, 0, 0, 0);
    do_fetch(32'h0100_00EF, 0); steps(5);

    // jalr x1,4(x2)
    ex(16, 1, RA, 2, 0, 0, 0, 0);
    ex(16, 2, IB, 0, 0, 0, 1, 32'd4);
    ex(16, 3, PC_INC, 0, 0, 0, 0, 0);
    ex(16, 4, PC_BUS | REG_WRITE, 1, 0, 0, 0, 0);
    ex(16, 5, ALU_BUS | PC_WRITE | DONE, 0, 0, 0, 0, 0);
    do_fetch(32'h0041_00E7, 0); steps(5);

    // jal interrupted by reset in step 4, then fetch resumes with lui
    ex(17, 1, PA, 0, 0, 0, 0, 0);
    ex(17, 2, IB, 0, 0, 0, 1, 32'd16);
    ex(17, 3, PC_INC, 0, 0, 0, 0, 0);
    do_fetch(32'h0100_00EF, 0); steps(3);
    rst_cycles(2);
    ex(18, 1, IMM_OE | REG_WRITE | PC_INC | DONE, 5, 0, 0, 1, 32'h1234_5000);
    do_fetch(32'h1234_52B7, 0); steps(1);

    // illegal encodings: unlisted opcode, reserved branch funct3, ir[1:0]!=11
    illegal_test(19, 32'hFFFF_FFFF);
    illegal_test(20, 32'h0020_A463);
    illegal_test(21, 32'h0070_0290);

    // sequencer is usable again after the trap was cleared
    ex(22, 1, RA, 0, 0, 0, 0, 0);
    ex(22, 2, IB, 0, 0, 0, 1, 32'd7);
    ex(22, 3, ALU_BUS | REG_WRITE | PC_INC | DONE, 5, 0, 0, 0, 0);
    do_fetch(32'h0070_0293, 0); steps(3);

    mem_ready = 1'b0;
    steps(3);
    chk("queue_drained", 32'(q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/microseq_ctrl.md
Name: microseq_ctrl

Overview:
- Parametrised microcoded control sequencer for the multi-cycle RV32I/RV64I datapath.
- Owns the instruction register, step counter and immediate decode. Drives all datapath strobes for the supported opcodes.
- Adds memory wait states, branch-condition evaluation, x0 write suppression, an illegal-instruction trap and funct3/funct7-driven ALU ops.
- Control outputs are combinational from registered {ir, step}; the datapath samples them at posedge clk.

Parameters:
- XLEN, 32, data/immediate width (32 or 64); immediates sign-extended to XLEN.
- STEP_BITS, 3, step-counter width; must be >=3 because the longest sequence is 6 steps.
- TRAP_ON_ILLEGAL, 1, 1 = illegal instruction halts with trap; 0 = executes as NOP (pc_inc, done).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- bus_in  in  XLEN  shared bus value; captured into ir at fetch
- mem_ready  in  1  memory ack; 0 stalls any mem_read/mem_write step
- alu_eq, alu_lt, alu_ltu  in  1 each  ALU compare flags of current A,B
- imm_out  out  XLEN  decoded immediate
- imm_oe  out  1  imm_out onto bus
- reg_idx  out  5  register index; 0 when none selected
- pc_addr, pc_bus, pc_inc, pc_write  out  1 each  PC strobes
- mem_read, mem_write  out  1 each  memory strobes
- mem_size  out  3  funct3 during memory steps, else 0
- reg_en, reg_write  out  1 each  regfile drive bus / write from bus
- a_write, b_write  out  1 each  ALU operand latches
- alu_bus, alu_addr  out  1 each  ALU result onto bus / addr
- alu_op  out  4  {funct7[5], funct3} in OP/OP-IMM result step, else 0 (ADD)
- step  out  STEP_BITS  current step
- instr_done  out  1  high in final step when it advances
- trap  out  1  sticky illegal-instruction flag

Behaviour:
- Synchronous reset: ir<=0x00000013 (NOP), step<=0, trap<=0. While reset is high, every output is 0 except imm_out (don't-care).
- Step 0 (fetch) drives pc_addr and mem_read.
  - On posedge with mem_ready=1: ir<=bus_in, step<=1.
  - With mem_ready=0: hold.
- Any step asserting mem_read/mem_write holds {ir, step} while mem_ready=0, with outputs stable.
- Final step: step<=0 and instr_done=1. Other steps: step+1.
- reg_write is forced 0 when rd=0.
- Sequences (steps 1..n):
  - LUI: imm_oe, reg_idx=rd, reg_write, pc_inc, end.
  - AUIPC: pc_bus+a_write; imm_oe+b_write; alu_bus+rd write+pc_inc, end.
  - JAL: pc_bus+a_write; imm_oe+b_write; pc_inc; pc_bus+rd write; alu_bus+pc_write, end.
  - JALR: as JAL, but step 1 is reg_idx=rs1+reg_en+a_write. LSB clearing is done by the datapath.
  - BRANCH:
    - Steps 1–2: rs1→A; rs2→B.
    - Step 3 evaluates cond from funct3: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
    - Not taken: pc_inc, end.
    - Taken: pc_bus+a_write; imm_oe+b_write; alu_bus+pc_write, end.
  - LOAD: rs1→A; imm→B; alu_addr+mem_read+rd write+pc_inc, end.
  - STORE: rs1→A; imm→B; alu_addr+reg_idx=rs2+reg_en+mem_write+pc_inc, end.
  - OP-IMM: rs1→A; imm→B; alu_bus+rd write+pc_inc, end. alu_op[3] = funct7[5] only for funct3=101.
  - OP: rs1→A; rs2→B; alu_bus+rd write+pc_inc, end.
- Immediate formats I/S/B/U/J are decoded per opcode; U- and J-type without shift beyond spec.
- Illegal cases: unlisted opcode, ir[1:0]!=11, branch funct3 010/011.
  - TRAP_ON_ILLEGAL=1: after fetch, trap<=1, step held at 1 with all strobes 0 until reset.
  - TRAP_ON_ILLEGAL=0: step 1 = pc_inc, end.
- Reset mid-sequence: next edge behaves as the reset state; no partial strobes.

Test Plan:
- Fetch 0x00700293 (addi x5,x0,7), mem_ready=1 -> step1 reg_idx=0,reg_en,a_write; step2 imm_out=7,b_write; step3 alu_bus,reg_idx=5,reg_write,pc_inc,alu_op=0,instr_done; 4 cycles total.
- 0x00208463 (beq x1,x2,8) with alu_eq=1 at step3 -> step3 pc_bus,a_write; step4 imm_out=8; step5 pc_write; 6 cycles. With alu_eq=0 -> step3 pc_inc,instr_done; 4 cycles.
- 0x0040a183 (lw x3,4(x1)), mem_ready=0 for 2 cycles in step3 -> step3 held 3 cycles, mem_size=010, imm_out=4, reg_idx=3, single instr_done.
- 0xFFFFFFFF with TRAP_ON_ILLEGAL=1 -> trap=1 and all strobes 0 indefinitely; reset clears trap. With TRAP_ON_ILLEGAL=0 -> pc_inc, instr_done, trap=0.
- 0x00000013 (addi x0,x0,0) -> reg_write never asserted; pc_inc in step3.
- Reset asserted during JAL step4 -> next cycle step=0, all outputs 0 while reset high; fetch resumes on release.
